hwpe_job_sequencer: RTL and testbench
=====================================

Name: hwpe_job_sequencer

Overview:
- Autonomous controller that programs and launches jobs on the FC-side HWPE through its 32-bit peripheral configuration port, so the core is not stalled on per-register APB traffic.
- Accepts whole job descriptors from a small FIFO. For each job it acquires the HWPE context, writes N_REGS job registers, triggers the job, then waits for the HWPE end-of-job event.
- Sits between the FC peripheral interconnect (descriptor push) and the HWPE periph slave port, in parallel with the APB-to-periph bridge path.

Parameters:
- N_REGS, 8, number of 32-bit job registers written per job
- FIFO_DEPTH, 2, descriptor FIFO entries (power of two, >=2)
- BASE_ADDR, 32'h0000_0000, HWPE periph base address
- TRIG_OFFSET, 32'h00, trigger register offset
- ACQ_OFFSET, 32'h04, acquire register offset
- REG_OFFSET, 32'h40, first job register offset; register i lives at REG_OFFSET+4*i
- TIMEOUT, 65535, maximum cycles in WAIT_EVT before error; 0 disables the timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- job_valid_i  in  1  descriptor push valid
- job_ready_o  out  1  FIFO not full
- job_data_i  in  32*N_REGS  descriptor; word i (bits [32i+31:32i]) goes to job register i
- periph_req_o  out  1  config request
- periph_gnt_i  in  1  config grant
- periph_add_o  out  32  config address
- periph_wen_o  out  1  0 = write, 1 = read
- periph_be_o  out  4  byte enables, always 4'hF
- periph_wdata_o  out  32  write data
- periph_r_valid_i  in  1  response valid
- periph_r_rdata_i  in  32  response data
- evt_i  in  1  HWPE end-of-job event, single-cycle pulse
- job_done_o  out  1  one-cycle pulse when a job completes
- job_error_o  out  1  one-cycle pulse on timeout
- job_id_o  out  8  id returned by the last successful acquire
- busy_o  out  1  FSM not IDLE, or FIFO not empty

Behaviour:
- Reset (asynchronous): FIFO emptied; FSM to IDLE. Outputs: periph_req_o=0, periph_add_o=0, periph_wen_o=1, periph_wdata_o=0, job_done_o=0, job_error_o=0, job_id_o=0, busy_o=0, job_ready_o=1 after reset release. A reset mid-transaction abandons the transaction; any later r_valid is ignored while in IDLE.
- FIFO:
  - Push when job_valid_i && job_ready_o.
  - Pop occurs at the transition into ACQ.
  - A simultaneous push and pop on a full FIFO is not allowed: job_ready_o depends on the registered count only.
- Periph handshake:
  - req, add, wen and wdata are held stable from assertion until the gnt cycle; req is deasserted in the cycle after gnt.
  - Exactly one outstanding transaction at a time.
  - The next req may assert no earlier than the cycle after r_valid.
  - r_valid may arrive 1 or more cycles after gnt, including in the cycle immediately following gnt.
- FSM:
  - IDLE: if FIFO not empty, pop into the descriptor register, go to ACQ.
  - ACQ: read BASE_ADDR+ACQ_OFFSET. On r_valid:
    - if rdata[31]=1 (HWPE busy), reissue the read in the next allowed cycle (unbounded retry);
    - otherwise set job_id_o=rdata[7:0], clear reg index k=0, go to PROG.
  - PROG: write descriptor word k to BASE_ADDR+REG_OFFSET+4k. On r_valid, k++; after the write with k=N_REGS-1 completes, go to TRIG.
  - TRIG: write 0 to BASE_ADDR+TRIG_OFFSET. On r_valid, go to WAIT_EVT and clear the timeout counter.
  - WAIT_EVT: on event (see event latching), pulse job_done_o, go to IDLE. If TIMEOUT!=0 and the counter reaches TIMEOUT with no event, pulse job_error_o and go to IDLE.
- Event latching:
  - A sticky flag sets on evt_i from the TRIG gnt cycle onward. This covers an event arriving before or together with the trigger r_valid.
  - evt_i outside TRIG/WAIT_EVT is ignored. The flag clears on leaving WAIT_EVT.
- Throughput: a back-to-back queued job enters ACQ one cycle after the job_done_o pulse of the previous job.
- Address arithmetic is modulo 2^32; offsets are unsigned.
- Timeout counter is 32-bit saturating and counts only in WAIT_EVT.

Test Plan:
- Single job, N_REGS=8, zero-wait gnt, r_valid one cycle after gnt, acquire returns 0x05, evt 10 cycles after trigger -> 1 read of 0x04, 8 writes to 0x40..0x5C with the descriptor words in order, write 0 to 0x00, job_id_o=0x05, one job_done_o pulse, busy_o drops the cycle after.
- Acquire returns 0xFFFFFFFF twice, then 0x02 -> exactly 3 acquire reads, no PROG writes before the third response, job_id_o=0x02.
- Push 3 descriptors back-to-back with FIFO_DEPTH=2 while the first job runs -> job_ready_o low when full; all 3 jobs execute in push order; 3 job_done_o pulses.
- Random gnt stall 0–5 cycles per request -> add, wdata and wen stable while req=1 and gnt=0; never two outstanding requests.
- TIMEOUT=20, evt never asserted -> job_error_o pulses exactly 20 cycles after entering WAIT_EVT, no job_done_o, next job proceeds. evt_i in the same cycle as the trigger r_valid -> job_done_o with no timeout.
- Assert rst_ni low mid-PROG (k=3) -> periph_req_o=0 immediately, FIFO empty, busy_o=0. A stray r_valid after release causes no state change.

Source files
------------

// File: rtl/hwpe_job_sequencer.sv
// Job sequencer for the FC-side HWPE: pulls job descriptors from a small FIFO,
// acquires the HWPE, programs the job registers, triggers and waits for end-of-job.
module hwpe_job_sequencer #(
    parameter int unsigned N_REGS      = 8,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] TRIG_OFFSET = 32'h00,
    parameter logic [31:0] ACQ_OFFSET  = 32'h04,
    parameter logic [31:0] REG_OFFSET  = 32'h40,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [32*N_REGS-1:0]  job_data_i,
    output logic                  periph_req_o,
    input  logic                  periph_gnt_i,
    output logic [31:0]           periph_add_o,
    output logic                  periph_wen_o,
    output logic [3:0]            periph_be_o,
    output logic [31:0]           periph_wdata_o,
    input  logic                  periph_r_valid_i,
    input  logic [31:0]           periph_r_rdata_i,
    input  logic                  evt_i,
    output logic                  job_done_o,
    output logic                  job_error_o,
    output logic [7:0]            job_id_o,
    output logic                  busy_o
);

    localparam int unsigned KW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        PROG,
        TRIG,
        WAIT_EVT
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            pend_q, pend_d;
    logic [31:0]     add_q, add_d;
    logic            wen_q, wen_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [KW-1:0]   k_q, k_d, k_next;
    logic [7:0]      id_q, id_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            evt_flag_q, evt_flag_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [32*N_REGS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q;
    logic                 push, pop;
    logic [31:0]          desc_q [N_REGS];

    logic gnt_acc, rsp;
    logic unused_rdata;

    assign unused_rdata = ^periph_r_rdata_i[30:8];

    // Ready looks only at the registered count, so a full FIFO never accepts
    // a push even in the cycle it pops.
    assign job_ready_o = (count_q != CW'(FIFO_DEPTH));
    assign push        = job_valid_i && job_ready_o;

    assign gnt_acc = req_q && periph_gnt_i;
    assign rsp     = pend_q && periph_r_valid_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wptr_q] <= job_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                desc_q[i] <= fifo_mem[rptr_q][32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            add_q      <= '0;
            wen_q      <= 1'b1;
            wdata_q    <= '0;
            k_q        <= '0;
            id_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            evt_flag_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            add_q      <= add_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            k_q        <= k_d;
            id_q       <= id_d;
            done_q     <= done_d;
            err_q      <= err_d;
            evt_flag_q <= evt_flag_d;
            cnt_q      <= cnt_d;
        end
    end

    // Every new request is registered off a response, so req can rise no
    // earlier than the cycle after r_valid and only one is ever outstanding.
    always_comb begin
        state_d    = state_q;
        req_d      = gnt_acc ? 1'b0 : req_q;
        pend_d     = gnt_acc ? 1'b1 : (rsp ? 1'b0 : pend_q);
        add_d      = add_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        k_d        = k_q;
        k_next     = k_q + KW'(1);
        id_d       = id_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        evt_flag_d = evt_flag_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                evt_flag_d = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ACQ;
                    req_d   = 1'b1;
                    add_d   = BASE_ADDR + ACQ_OFFSET;
                    wen_d   = 1'b1;
                    wdata_d = '0;
                end
            end

            ACQ: begin
                if (rsp) begin
                    req_d = 1'b1;
                    if (!periph_r_rdata_i[31]) begin
                        id_d    = periph_r_rdata_i[7:0];
                        k_d     = '0;
                        state_d = PROG;
                        add_d   = BASE_ADDR + REG_OFFSET;
                        wen_d   = 1'b0;
                        wdata_d = desc_q[0];
                    end
                end
            end

            PROG: begin
                if (rsp) begin
                    req_d = 1'b1;
                    wen_d = 1'b0;
                    if (k_q == KW'(N_REGS - 1)) begin
                        state_d = TRIG;
                        add_d   = BASE_ADDR + TRIG_OFFSET;
                        wdata_d = '0;
                    end else begin
                        k_d     = k_next;
                        add_d   = BASE_ADDR + REG_OFFSET + (32'(k_next) << 2);
                        wdata_d = desc_q[k_next];
                    end
                end
            end

            TRIG: begin
                // The HWPE may finish before the trigger write is acknowledged.
                if ((gnt_acc || pend_q) && evt_i) begin
                    evt_flag_d = 1'b1;
                end
                if (rsp) begin
                    state_d = WAIT_EVT;
                    cnt_d   = '0;
                end
            end

            WAIT_EVT: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (evt_i || evt_flag_q) begin
                    done_d     = 1'b1;
                    evt_flag_d = 1'b0;
                    state_d    = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_d >= TIMEOUT)) begin
                    err_d      = 1'b1;
                    evt_flag_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign periph_req_o   = req_q;
    assign periph_add_o   = add_q;
    assign periph_wen_o   = wen_q;
    assign periph_be_o    = 4'hF;
    assign periph_wdata_o = wdata_q;
    assign job_done_o     = done_q;
    assign job_error_o    = err_q;
    assign job_id_o       = id_q;
    assign busy_o         = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_hwpe_job_sequencer.sv
// Self-checking bench for hwpe_job_sequencer: an HWPE periph slave model with a
// transaction scoreboard plus an outcome scoreboard for done/error pulses.
module tb_hwpe_job_sequencer;

    localparam int N_REGS = 8;
    localparam logic [31:0] ACQ_ADDR  = 32'h04;
    localparam logic [31:0] TRIG_ADDR = 32'h00;
    localparam logic [31:0] REG_ADDR  = 32'h40;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic       is_err;
        logic [7:0] id;
    } out_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 job_valid;
    logic                 job_ready;
    logic [32*N_REGS-1:0] job_data;
    logic                 periph_req;
    logic                 periph_gnt;
    logic [31:0]          periph_add;
    logic                 periph_wen;
    logic [3:0]           periph_be;
    logic [31:0]          periph_wdata;
    logic                 periph_r_valid;
    logic [31:0]          periph_r_rdata;
    logic                 evt;
    logic                 job_done;
    logic                 job_error;
    logic [7:0]           job_id;
    logic                 busy;

    txn_t        exp_q[$];
    logic [31:0] acq_q[$];
    int          evt_q[$];
    out_t        out_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int outcomes_seen = 0;
    int stall_max = 0;
    int rv_max = 1;
    bit stray_req = 1'b0;
    int trig_cyc = 0;

    always #5 clk = ~clk;

    hwpe_job_sequencer #(
        .N_REGS(N_REGS),
        .FIFO_DEPTH(2),
        .TIMEOUT(20)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .job_valid_i(job_valid),
        .job_ready_o(job_ready),
        .job_data_i(job_data),
        .periph_req_o(periph_req),
        .periph_gnt_i(periph_gnt),
        .periph_add_o(periph_add),
        .periph_wen_o(periph_wen),
        .periph_be_o(periph_be),
        .periph_wdata_o(periph_wdata),
        .periph_r_valid_i(periph_r_valid),
        .periph_r_rdata_i(periph_r_rdata),
        .evt_i(evt),
        .job_done_o(job_done),
        .job_error_o(job_error),
        .job_id_o(job_id),
        .busy_o(busy)
    );

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // HWPE periph slave: random grant stall, response latency, acquire data and
    // end-of-job events scheduled relative to the trigger response.
    initial begin
        bit          seen = 1'b0;
        bit          outstanding = 1'b0;
        bit          is_trig = 1'b0;
        int          wait_cnt = 0;
        int          rv_cnt = 0;
        int          evt_cnt = 0;
        int          d;
        logic [64:0] hold = '0;
        logic [31:0] rsp_data = '0;
        txn_t        e;
        periph_gnt = 1'b0;
        periph_r_valid = 1'b0;
        periph_r_rdata = '0;
        evt = 1'b0;
        forever begin
            @(negedge clk);
            periph_gnt = 1'b0;
            periph_r_valid = 1'b0;
            evt = 1'b0;
            if (!rst_n) begin
                seen = 1'b0;
                outstanding = 1'b0;
                evt_cnt = 0;
            end else begin
                if (evt_cnt > 0) begin
                    evt_cnt--;
                    if (evt_cnt == 0) evt = 1'b1;
                end
                if (stray_req) begin
                    periph_r_valid = 1'b1;
                    periph_r_rdata = 32'h0000_0007;
                    stray_req = 1'b0;
                end else if (outstanding) begin
                    checkOutput("one_outstanding", 65'(periph_req), 65'(0));
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        periph_r_valid = 1'b1;
                        periph_r_rdata = rsp_data;
                        outstanding = 1'b0;
                        if (is_trig) begin
                            trig_cyc = cyc;
                            d = (evt_q.size() > 0) ? evt_q.pop_front() : -1;
                            if (d == 0) evt = 1'b1;
                            else if (d > 0) evt_cnt = d;
                        end
                    end
                end else if (periph_req) begin
                    if (!seen) begin
                        seen = 1'b1;
                        hold = {periph_add, periph_wen, periph_wdata};
                        wait_cnt = int'($urandom_range(0, stall_max));
                    end else begin
                        checkOutput("req_stable", {periph_add, periph_wen, periph_wdata}, hold);
                    end
                    if (wait_cnt == 0) begin
                        periph_gnt = 1'b1;
                        seen = 1'b0;
                        outstanding = 1'b1;
                        rv_cnt = int'($urandom_range(1, rv_max));
                        is_trig = !periph_wen && (periph_add == TRIG_ADDR);
                        checkOutput("be", 65'(periph_be), 65'(4'hF));
                        checkOutput("txn_expected", 65'(exp_q.size() > 0), 65'(1));
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            if (e.wen)
                                checkOutput("txn_read", {periph_add, periph_wen, 32'h0}, {e.add, 1'b1, 32'h0});
                            else
                                checkOutput("txn_write", {periph_add, periph_wen, periph_wdata}, e);
                        end
                        rsp_data = '0;
                        if (periph_wen && acq_q.size() > 0) rsp_data = acq_q.pop_front();
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Outcome scoreboard: each done/error pulse is matched against the queue.
    initial begin
        out_t o;
        forever begin
            @(negedge clk);
            if (rst_n && (job_done || job_error)) begin
                outcomes_seen++;
                checkOutput("outcome_expected", 65'(out_q.size() > 0), 65'(1));
                if (out_q.size() > 0) begin
                    o = out_q.pop_front();
                    checkOutput("outcome_kind", {63'h0, job_done, job_error}, {63'h0, !o.is_err, o.is_err});
                    checkOutput("outcome_id", 65'(job_id), 65'(o.id));
                    if (o.is_err) checkOutput("timeout_latency", 65'(cyc - trig_cyc), 65'(21));
                end
            end
        end
    end

    // Queue the expected bus traffic and outcome of one job, then push it.
    task automatic applyStimulus(input int n_busy, input logic [7:0] id, input int evt_delay);
        logic [32*N_REGS-1:0] data;
        int budget = 2000;
        for (int i = 0; i < N_REGS; i++) data[32*i +: 32] = $urandom;
        @(negedge clk);
        while (!job_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("push_ready", 65'(job_ready), 65'(1));
        for (int b = 0; b <= n_busy; b++) exp_q.push_back({ACQ_ADDR, 1'b1, 32'h0});
        for (int b = 0; b < n_busy; b++) acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back({24'h0, id});
        for (int i = 0; i < N_REGS; i++)
            exp_q.push_back({REG_ADDR + 32'(4 * i), 1'b0, data[32*i +: 32]});
        exp_q.push_back({TRIG_ADDR, 1'b0, 32'h0});
        evt_q.push_back(evt_delay);
        out_q.push_back({(evt_delay < 0), id});
        job_valid = 1'b1;
        job_data = data;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic waitOutcomes(input int target);
        int budget = 3000;
        while (outcomes_seen < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checkOutput("outcome_count", 65'(outcomes_seen), 65'(target));
    endtask

    initial begin
        int budget;
        job_valid = 1'b0;
        job_data = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req", 65'(periph_req), 65'(0));
        checkOutput("rst_add", 65'(periph_add), 65'(0));
        checkOutput("rst_wen", 65'(periph_wen), 65'(1));
        checkOutput("rst_wdata", 65'(periph_wdata), 65'(0));
        checkOutput("rst_done_err", {63'h0, job_done, job_error}, 65'(0));
        checkOutput("rst_id", 65'(job_id), 65'(0));
        checkOutput("rst_busy", 65'(busy), 65'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 65'(job_ready), 65'(1));

        $display("[TB] single job");
        applyStimulus(0, 8'h05, 10);
        waitOutcomes(1);
        checkOutput("id_job1", 65'(job_id), 65'(8'h05));
        @(negedge clk);
        checkOutput("busy_after_done", 65'(busy), 65'(0));
        checkOutput("txn_left_1", 65'(exp_q.size()), 65'(0));

        $display("[TB] acquire retry");
        applyStimulus(2, 8'h02, 3);
        waitOutcomes(2);
        checkOutput("id_retry", 65'(job_id), 65'(8'h02));
        checkOutput("acq_left", 65'(acq_q.size()), 65'(0));

        $display("[TB] fifo backpressure");
        applyStimulus(0, 8'h11, 5);
        applyStimulus(0, 8'h12, 4);
        applyStimulus(0, 8'h13, 6);
        checkOutput("ready_full", 65'(job_ready), 65'(0));
        checkOutput("busy_full", 65'(busy), 65'(1));
        waitOutcomes(5);
        checkOutput("id_last_queued", 65'(job_id), 65'(8'h13));

        $display("[TB] random grant stalls");
        stall_max = 5;
        rv_max = 3;
        applyStimulus(1, 8'h21, 7);
        applyStimulus(0, 8'h22, 2);
        waitOutcomes(7);
        stall_max = 0;
        rv_max = 1;

        $display("[TB] timeout then same-cycle event");
        applyStimulus(0, 8'h31, -1);
        applyStimulus(0, 8'h32, 0);
        waitOutcomes(9);
        checkOutput("txn_left_5", 65'(exp_q.size()), 65'(0));

        $display("[TB] reset mid-PROG");
        applyStimulus(0, 8'h41, 5);
        budget = 2000;
        while (!(periph_req && periph_add == 32'h4C) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("reached_k3", {32'h0, periph_req, periph_add}, {32'h0, 1'b1, 32'h4C});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", 65'(periph_req), 65'(0));
        checkOutput("midrst_busy", 65'(busy), 65'(0));
        checkOutput("midrst_ready", 65'(job_ready), 65'(1));
        exp_q.delete();
        acq_q.delete();
        evt_q.delete();
        out_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray_req = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stray_req", 65'(periph_req), 65'(0));
            checkOutput("stray_busy", 65'(busy), 65'(0));
        end
        checkOutput("stray_id", 65'(job_id), 65'(0));

        $display("[TB] recovery job");
        applyStimulus(0, 8'h51, 4);
        waitOutcomes(10);
        checkOutput("id_recovery", 65'(job_id), 65'(8'h51));
        checkOutput("txn_left_end", 65'(exp_q.size()), 65'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
